// File: rtl/ctrl_trace_encoder.sv
// ctrl_trace_encoder
//   Re-encodes the decoded ID-stage control bundle into a 6-bit opcode. It then
//   queues the non-bubble results in a 4-entry FIFO for a trace consumer. The
//   input side never stalls. A bundle that arrives while the FIFO is full is
//   dropped, and it is tallied in a saturating drop counter.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   in_valid          control bundle valid this cycle
//   RegDst..MemtoReg  decoded control bits
//   ALUOp[1:0]        decoded ALU operation class
//   in_ready          FIFO not full (advisory only)
//   out_valid         head entry available
//   out_ready         consumer takes the head entry this cycle
//   out_opcode[5:0]   head entry opcode (forced to 0 when empty)
//   out_illegal       head entry matched no legal pattern
//   count[2:0]        FIFO occupancy, 0..4
//   drop_count[7:0]   saturating count of dropped entries
module ctrl_trace_encoder (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic       RegDst,
   input  logic       RegWrite,
   input  logic       ALUSrc,
   input  logic       MemWrite,
   input  logic       MemRead,
   input  logic       MemtoReg,
   input  logic [1:0] ALUOp,
   output logic       in_ready,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [5:0] out_opcode,
   output logic       out_illegal,
   output logic [2:0] count,
   output logic [7:0] drop_count
);

   localparam logic [2:0] DEPTH = 3'd4;

   logic [7:0] bundle;
   logic       bubble;
   logic [5:0] enc_opcode;
   logic       enc_illegal;
   logic [6:0] mem [4];
   logic [1:0] wr_ptr;
   logic [1:0] rd_ptr;
   logic       eligible;
   logic       push;
   logic       drop;
   logic       pop;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign bundle = {ALUOp, RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemtoReg};
   // Bundles that write nothing carry no trace information.
   assign bubble = !RegWrite && !MemWrite && !MemRead;

   always_comb begin
      enc_opcode  = 6'b111111;
      enc_illegal = 1'b1;
      casez (bundle)
         8'b10110000: begin enc_opcode = 6'b000100; enc_illegal = 1'b0; end // R-format
         8'b00011000: begin enc_opcode = 6'b001100; enc_illegal = 1'b0; end // addiu
         8'b01011000: begin enc_opcode = 6'b001101; enc_illegal = 1'b0; end // subiu
         8'b00?0110?: begin enc_opcode = 6'b010000; enc_illegal = 1'b0; end // sw
         8'b00011011: begin enc_opcode = 6'b010001; enc_illegal = 1'b0; end // lw
         default:     begin enc_opcode = 6'b111111; enc_illegal = 1'b1; end
      endcase
   end

   // Fullness is judged on the pre-edge count, so a same-cycle pop does not
   // rescue a push that arrives while the FIFO is full.
   assign eligible = in_valid && !bubble;
   assign push     = eligible && (count != DEPTH);
   assign drop     = eligible && (count == DEPTH);
   assign pop      = out_valid && out_ready;

   assign in_ready    = (count != DEPTH);
   assign out_valid   = (count != 3'd0);
   // The data storage is not reset, so the outputs are masked while empty.
   assign out_opcode  = out_valid ? mem[rd_ptr][5:0] : 6'b000000;
   assign out_illegal = out_valid ? mem[rd_ptr][6]   : 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= 2'd0;
         rd_ptr     <= 2'd0;
         count      <= 3'd0;
         drop_count <= 8'd0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 2'd1;
         if (pop)  rd_ptr <= rd_ptr + 2'd1;
         if (push && !pop)      count <= count + 3'd1;
         else if (pop && !push) count <= count - 3'd1;
         if (drop) drop_count <= sat_inc(drop_count);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {enc_illegal, enc_opcode};
   end

endmodule

// File: doc/ctrl_trace_encoder.md
CTRL_TRACE_ENCODER -- requirements
Module: ctrl_trace_encoder

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; all state resets asynchronously and is otherwise updated only on the rising clk edge.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  control bundle on the inputs below is valid this cycle.
REQ-005 RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemtoReg  input  1 each  decoded control bits from the ID stage.
REQ-006 ALUOp  input  2  decoded ALU operation class.
REQ-007 in_ready  output  1  high when the FIFO can accept an entry (count != 4).
REQ-008 out_valid  output  1  head entry available.
REQ-009 out_ready  input  1  consumer accepts the head entry this cycle.
REQ-010 out_opcode  output  6  re-encoded opcode of the head entry.
REQ-011 out_illegal  output  1  head entry matched no legal pattern.
REQ-012 count  output  3  FIFO occupancy, 0..4.
REQ-013 drop_count  output  8  saturating count of dropped entries.

Function
REQ-014 SHALL encode each bundle combinationally as follows; x means the bit is ignored:
- ALUOp=10, RegDst=1, RegWrite=1, ALUSrc=0, MemWrite=0, MemRead=0, MemtoReg=0 -> 000100 (R-format)
- ALUOp=00, RegDst=0, RegWrite=1, ALUSrc=1, MemWrite=0, MemRead=0, MemtoReg=0 -> 001100 (addiu)
- ALUOp=01, same bits as addiu -> 001101 (subiu)
- ALUOp=00, RegDst=x, RegWrite=0, ALUSrc=1, MemWrite=1, MemRead=0, MemtoReg=x -> 010000 (sw)
- ALUOp=00, RegDst=0, RegWrite=1, ALUSrc=1, MemWrite=0, MemRead=1, MemtoReg=1 -> 010001 (lw)
REQ-015 SHALL classify a bundle as a bubble when RegWrite=0, MemWrite=0 and MemRead=0, regardless of the other bits; a bubble is never enqueued and never counted.
REQ-016 SHALL encode any other non-bubble bundle as opcode 111111 with illegal=1; legal entries carry illegal=0.
REQ-017 SHALL store entries in a 4-entry FIFO, 7 bits per entry ({illegal, opcode}), using 2-bit read and write pointers that wrap from 3 to 0.
REQ-018 A push SHALL occur when in_valid=1, the bundle is not a bubble, and count<4.
REQ-019 A pop SHALL occur when out_valid=1 and out_ready=1.
REQ-020 There SHALL be no bypass: an entry pushed at edge N is visible on out_* from edge N onward, so it can be popped no earlier than edge N+1.
REQ-021 out_valid SHALL equal (count != 0); out_opcode and out_illegal SHALL be driven from the head entry and are don't-care when out_valid=0.
REQ-022 On a simultaneous push and pop with count between 1 and 3, count SHALL be unchanged and both pointers SHALL advance.
REQ-023 When count=4, an eligible push SHALL be dropped even if a pop occurs in the same cycle; drop_count SHALL increment, saturating at 255.
REQ-024 The input side SHALL never stall the pipeline; in_ready is advisory only.
REQ-025 count SHALL move by at most 1 per cycle and SHALL never exceed 4 or underflow.

Reset
REQ-026 While rst=1, the block SHALL hold count=0, both pointers=0, drop_count=0, out_valid=0, in_ready=1, out_opcode=000000 and out_illegal=0.
REQ-027 Asserting rst mid-operation SHALL discard all FIFO contents immediately, without waiting for a clock edge.
REQ-028 FIFO data storage need not be reset.

Verification
REQ-029 Push R-format then lw, with out_ready=0 -> count=2; on raising out_ready, pops yield 000100 then 010001, both with illegal=0.
REQ-030 Push sw with RegDst=1 and MemtoReg=1 -> the popped entry is 010000 with illegal=0.
REQ-031 Push a bundle with ALUOp=11 and RegWrite=1 -> the popped entry is 111111 with illegal=1; a bundle with RegWrite=0, MemWrite=0, MemRead=0 and ALUOp=10 -> nothing enqueued and count unchanged.
REQ-032 Six consecutive addiu pushes with out_ready=0 -> count=4, in_ready=0, drop_count=2; the four pops all yield 001100.
REQ-033 With count=4 and out_ready=1, push subiu -> the push is dropped, count=3 and drop_count increments; sustained push and pop at count=2 -> count stays at 2 and order is preserved.
REQ-034 Assert rst asynchronously while count=3 -> count=0 and out_valid=0 before the next clk edge; after release, a push of addiu pops as 001100.
